// File: rtl/riscv16_pkg.sv
// Shared definitions for the 16-bit RISC pipeline.
// Default bus widths and the store-buffer entry layout.
package riscv16_pkg;

   localparam int RV16_AW = 16;
   localparam int RV16_DW = 16;

   typedef struct packed {
      logic [RV16_AW-1:0] addr;
      logic [RV16_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_cam_match.sv
// Age-ordered address compare over the live store-buffer entries.
// Combinational; reports a hit and the index of the youngest matching entry.
module sb_cam_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 16,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = PW + 1
) (
   input  logic [AW-1:0] entry_addr [DEPTH],
   input  logic [PW-1:0] head,
   input  logic [CW-1:0] count,
   input  logic [AW-1:0] req_addr,
   output logic          hit,
   output logic [PW-1:0] hit_idx
);

   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last match seen is the youngest.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if ((k < int'(count)) && (entry_addr[idx] == req_addr)) begin
            hit     = 1'b1;
            hit_idx = idx;
         end
      end
   end

endmodule

// File: rtl/lsu_store_buffer.sv
// MEM-stage load/store unit: FIFO store buffer with load forwarding, draining into Data_Mem.
// Loads return one cycle after acceptance; a load miss stalls only while the buffer is full.
module lsu_store_buffer
   import riscv16_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = RV16_AW,
   parameter int DW    = RV16_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          req_ready,
   output logic          load_valid,
   output logic [DW-1:0] load_data,
   output logic          sb_empty,
   output logic          memRead,
   output logic          memWrite,
   output logic [AW-1:0] address,
   output logic [DW-1:0] write_data,
   input  logic [DW-1:0] read_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          load_valid_q, load_valid_d;
   logic [DW-1:0] load_data_q, load_data_d;

   logic          empty, full, is_load, hit, store_acc, load_acc;
   logic          drain_fire, load_miss_go;
   logic [PW-1:0] hit_idx;

   sb_cam_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .PW    (PW),
      .CW    (CW)
   ) u_cam (
      .entry_addr (addr_q),
      .head       (head_q),
      .count      (count_q),
      .req_addr   (req_addr),
      .hit        (hit),
      .hit_idx    (hit_idx)
   );

   always_comb begin
      empty        = (count_q == '0);
      full         = (count_q == CW'(DEPTH));
      is_load      = req_valid && !req_write;
      drain_fire   = !empty && (!req_valid || full);
      load_miss_go = is_load && !hit && !full;
      req_ready    = !(is_load && !hit && full);
      store_acc    = req_valid && req_write;
      load_acc     = is_load && req_ready;
   end

   // Data_Mem port: drain and miss are mutually exclusive by construction.
   always_comb begin
      memWrite   = drain_fire && !rst;
      memRead    = load_miss_go && !rst;
      address    = '0;
      write_data = '0;
      if (memWrite) begin
         address    = addr_q[head_q];
         write_data = data_q[head_q];
      end else if (memRead) begin
         address = req_addr;
      end
   end

   always_comb begin
      head_d       = drain_fire ? head_q + 1'b1 : head_q;
      tail_d       = store_acc ? tail_q + 1'b1 : tail_q;
      count_d      = count_q + CW'(store_acc) - CW'(drain_fire);
      load_valid_d = load_acc;
      load_data_d  = load_data_q;
      if (load_acc) begin
         load_data_d = hit ? data_q[hit_idx] : read_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         load_valid_q <= load_valid_d;
         load_data_q  <= load_data_d;
      end
   end

   // Entry storage needs no reset: validity is carried by head/count.
   always_ff @(posedge clk) begin
      if (store_acc) begin
         addr_q[tail_q] <= req_addr;
         data_q[tail_q] <= req_wdata;
      end
   end

   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;
   assign sb_empty   = empty;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer against a small Data_Mem model.
module tb_lsu_store_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [15:0] req_addr  = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready, load_valid, sb_empty, memRead, memWrite;
   logic [15:0] load_data, address, write_data, read_data;

   logic [15:0] mem [256];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   lsu_store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .load_valid (load_valid),
      .load_data  (load_data),
      .sb_empty   (sb_empty),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data)
   );

   assign read_data = memRead ? mem[address[7:0]] : 16'hDEAD;

   always @(posedge clk) begin
      if (memWrite) mem[address[7:0]] <= write_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, apply a request, let combinational outputs settle.
   task automatic step(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[20] = 16'd10;
      mem[30] = 16'd7;

      // Reset state, with a load presented while reset is held.
      step(1, 0, 16'd20, 0);
      chk("rst_load_valid", load_valid, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_sb_empty", sb_empty, 1);
      chk("rst_memRead", memRead, 0);
      chk("rst_memWrite", memWrite, 0);
      chk("rst_address", address, 0);
      rst = 1'b0;

      // 1. Load miss
      step(1, 0, 16'd20, 0);
      chk("t1_memRead", memRead, 1);
      chk("t1_address", address, 20);
      chk("t1_ready", req_ready, 1);
      step(0, 0, 0, 0);
      chk("t1_load_valid", load_valid, 1);
      chk("t1_load_data", load_data, 10);
      chk("t1_idle_memRead", memRead, 0);
      chk("t1_idle_address", address, 0);

      // 2. Store then hit
      step(1, 1, 16'd20, 16'd12);
      chk("t2_st_ready", req_ready, 1);
      chk("t2_st_memWrite", memWrite, 0);
      chk("t2_load_valid_drop", load_valid, 0);
      step(1, 0, 16'd20, 0);
      chk("t2_hit_memRead", memRead, 0);
      chk("t2_hit_ready", req_ready, 1);
      chk("t2_not_empty", sb_empty, 0);
      step(0, 0, 0, 0);
      chk("t2_load_valid", load_valid, 1);
      chk("t2_load_data", load_data, 12);
      chk("t2_mem_stale", mem[20], 10);
      chk("t2_drain_memWrite", memWrite, 1);
      chk("t2_drain_addr", address, 20);
      chk("t2_drain_data", write_data, 12);
      step(0, 0, 0, 0);
      chk("t2_empty_after", sb_empty, 1);
      chk("t2_mem_written", mem[20], 12);

      // 3. Youngest match wins
      step(1, 1, 16'd20, 16'd12);
      step(1, 1, 16'd20, 16'd13);
      step(1, 0, 16'd20, 0);
      chk("t3_hit_memRead", memRead, 0);
      step(0, 0, 0, 0);
      chk("t3_load_data", load_data, 13);
      chk("t3_drain0_data", write_data, 12);
      step(0, 0, 0, 0);
      chk("t3_drain1_data", write_data, 13);
      step(0, 0, 0, 0);
      chk("t3_empty", sb_empty, 1);
      chk("t3_mem", mem[20], 13);

      // 4. Fill and overflow
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 16'(i), 16'(100 + i));
         chk($sformatf("t4_fill%0d_memWrite", i), memWrite, 0);
         chk($sformatf("t4_fill%0d_ready", i), req_ready, 1);
      end
      step(1, 1, 16'd4, 16'd104);
      chk("t4_ovf_memWrite", memWrite, 1);
      chk("t4_ovf_addr", address, 0);
      chk("t4_ovf_data", write_data, 100);
      chk("t4_ovf_ready", req_ready, 1);
      step(1, 0, 16'd30, 0);
      chk("t4_stall_ready", req_ready, 0);
      chk("t4_stall_memRead", memRead, 0);
      chk("t4_stall_memWrite", memWrite, 1);
      chk("t4_stall_addr", address, 1);
      chk("t4_stall_data", write_data, 101);
      chk("t4_mem0", mem[0], 100);
      step(1, 0, 16'd30, 0);
      chk("t4_acc_ready", req_ready, 1);
      chk("t4_acc_memRead", memRead, 1);
      chk("t4_acc_addr", address, 30);
      chk("t4_acc_load_valid", load_valid, 0);

      // 5. Idle drain of the remaining three entries
      step(0, 0, 0, 0);
      chk("t4_load_valid", load_valid, 1);
      chk("t4_load_data", load_data, 7);
      for (int i = 2; i < 5; i++) begin
         if (i > 2) step(0, 0, 0, 0);
         chk($sformatf("t5_drain%0d_memWrite", i), memWrite, 1);
         chk($sformatf("t5_drain%0d_addr", i), address, 16'(i));
         chk($sformatf("t5_drain%0d_data", i), write_data, 16'(100 + i));
      end
      step(0, 0, 0, 0);
      chk("t5_empty", sb_empty, 1);
      chk("t5_memWrite_off", memWrite, 0);
      chk("t5_mem2", mem[2], 102);
      chk("t5_mem4", mem[4], 104);

      // 6. Async reset mid-drain
      step(1, 1, 16'd40, 16'd55);
      step(1, 1, 16'd41, 16'd56);
      step(1, 1, 16'd42, 16'd57);
      step(1, 0, 16'd40, 0);
      chk("t6_hit_memRead", memRead, 0);
      step(0, 0, 0, 0);
      chk("t6_load_valid", load_valid, 1);
      chk("t6_load_data", load_data, 55);
      chk("t6_drain_memWrite", memWrite, 1);
      chk("t6_drain_addr", address, 40);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_memWrite", memWrite, 0);
      chk("t6_rst_empty", sb_empty, 1);
      chk("t6_rst_load_valid", load_valid, 0);
      chk("t6_rst_address", address, 0);
      step(0, 0, 0, 0);
      rst = 1'b0;
      step(1, 0, 16'd41, 0);
      chk("t6_miss_memRead", memRead, 1);
      chk("t6_miss_addr", address, 41);
      step(1, 0, 16'd40, 0);
      chk("t6_miss41_data", load_data, 0);
      chk("t6_miss40_memRead", memRead, 1);
      step(0, 0, 0, 0);
      chk("t6_miss40_data", load_data, 0);
      chk("t6_mem40_untouched", mem[40], 0);
      chk("t6_mem41_untouched", mem[41], 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
